// File: rtl/periph_responder_pkg.sv
// Shared types for the peripheral responder: store widths, FSM states,
// register offsets and byte-lane helpers.
package periph_responder_pkg;

    typedef enum logic [2:0] {
        ST_NONE  = 3'd0,
        ST_BYTE  = 3'd1,
        ST_HALF  = 3'd2,
        ST_WORD  = 3'd3,
        ST_DWORD = 3'd4
    } mem_store_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } resp_state_t;

    localparam logic [63:0] OFF_SCRATCH0 = 64'h00;
    localparam logic [63:0] OFF_COUNT    = 64'h40;
    localparam logic [63:0] OFF_COMPARE  = 64'h48;
    localparam logic [63:0] WINDOW_BYTES = 64'h50;

    localparam logic [3:0] IDX_COUNT   = 4'(OFF_COUNT >> 3);
    localparam logic [3:0] IDX_COMPARE = 4'(OFF_COMPARE >> 3);

    // Byte lanes touched by a store before shifting to its start lane.
    function automatic logic [7:0] lane_mask(input mem_store_type_t st);
        case (st)
            ST_BYTE:  return 8'h01;
            ST_HALF:  return 8'h03;
            ST_WORD:  return 8'h0F;
            ST_DWORD: return 8'hFF;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic store_aligned(input mem_store_type_t st, input logic [2:0] lo);
        case (st)
            ST_HALF:  return lo[0] == 1'b0;
            ST_WORD:  return lo[1:0] == 2'b00;
            ST_DWORD: return lo == 3'b000;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/periph_responder_timer.sv
// Free-running COUNT with a byte-writable COMPARE and a sticky match interrupt
// that any COMPARE store clears.
module periph_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_be,
    input  logic [63:0] wr_data,
    output logic [63:0] count,
    output logic [63:0] compare,
    output logic        timer_irq
);

    logic [63:0] bit_mask;

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    // A COMPARE store in the match cycle wins over setting the interrupt.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count     <= '0;
            compare   <= '1;
            timer_irq <= 1'b0;
        end else begin
            count <= count + 64'd1;
            if (wr_en) begin
                compare   <= (compare & ~bit_mask) | (wr_data & bit_mask);
                timer_irq <= 1'b0;
            end else if (count == compare) begin
                timer_irq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_responder.sv
// Memory-mapped responder: eight scratch doublewords plus a timer, answering
// each request after a fixed number of wait cycles.
module periph_responder
    import periph_responder_pkg::*;
#(
    parameter logic [63:0] BASE        = 64'h2000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [63:0]     d_addr,
    input  logic [63:0]     d_wdata,
    input  mem_store_type_t d_store_type,
    input  logic            d_valid,
    output logic            d_ready,
    output logic [63:0]     d_rdata,
    output logic            bus_err,
    output logic            timer_irq
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    resp_state_t     state, state_next;
    logic [3:0]      wait_cnt;
    logic [63:0]     req_addr, req_wdata;
    mem_store_type_t req_type;
    logic [63:0]     scratch [8];

    logic [63:0] offset, read_val, store_data, count, compare;
    logic [3:0]  reg_idx;
    logic [2:0]  lane_lo;
    logic [7:0]  store_be;
    logic        in_window, is_store, access_err, commit, timer_wr;

    assign offset = req_addr - BASE;

    // Decode of the latched request; addresses below BASE wrap to huge offsets.
    always_comb begin
        in_window  = offset < WINDOW_BYTES;
        reg_idx    = offset[6:3];
        lane_lo    = offset[2:0];
        is_store   = req_type != ST_NONE;
        access_err = !in_window || (is_store && !store_aligned(req_type, lane_lo));
        commit     = reset && (state == S_RESP) && is_store && !access_err;
        timer_wr   = commit && (reg_idx == IDX_COMPARE);
        store_be   = lane_mask(req_type) << lane_lo;
        store_data = req_wdata << {lane_lo, 3'b000};
        read_val   = '0;
        if (reg_idx < IDX_COUNT) begin
            read_val = scratch[reg_idx[2:0]];
        end else if (reg_idx == IDX_COUNT) begin
            read_val = count;
        end else if (reg_idx == IDX_COMPARE) begin
            read_val = compare;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (d_valid) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_type  <= ST_NONE;
        end else begin
            state <= state_next;
            if (state == S_IDLE && d_valid) begin
                req_addr  <= d_addr;
                req_wdata <= d_wdata;
                req_type  <= d_store_type;
                wait_cnt  <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < 8; r++) scratch[r] <= '0;
        end else if (commit && reg_idx < IDX_COUNT) begin
            for (int b = 0; b < 8; b++) begin
                if (store_be[b]) scratch[reg_idx[2:0]][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    periph_timer u_timer (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (timer_wr),
        .wr_be     (store_be),
        .wr_data   (store_data),
        .count     (count),
        .compare   (compare),
        .timer_irq (timer_irq)
    );

    // Response outputs are forced low whenever reset is being applied.
    assign d_ready = reset && (state == S_RESP);
    assign bus_err = d_ready && access_err;
    assign d_rdata = (d_ready && !is_store && in_window) ? read_val : '0;

endmodule

// File: tb/tb_periph_responder.sv
// Bench for periph_responder: three instances (WAIT_CYCLES 1, 0, 3) checked every
// cycle against a timeline model, plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_periph_responder;
    import periph_responder_pkg::*;

    localparam logic [63:0] BASE = 64'h2000_0000;
    localparam int NI = 3;

    logic                 clock = 1'b0;
    logic [NI-1:0]        rst_n;
    logic [NI-1:0]        d_valid_v;
    logic [NI-1:0][63:0]  d_addr_v, d_wdata_v, d_rdata_v;
    mem_store_type_t      st_v [NI];
    logic [NI-1:0]        d_ready_v, bus_err_v, timer_irq_v;

    int tests_run = 0;
    int tests_failed = 0;

    bit              m_valid [NI];
    logic [63:0]     m_count [NI], m_cmp [NI], m_addr [NI], m_wdata [NI];
    logic [63:0]     m_scr [NI][8];
    bit              m_irq [NI], m_pend [NI];
    longint          m_cyc [NI], m_due [NI];
    mem_store_type_t m_st [NI];

    int          lat;
    logic [63:0] rd;
    logic        err;
    logic [63:0] b2b_addr [4];

    always #5 clock = ~clock;

    periph_responder #(.BASE(BASE), .WAIT_CYCLES(1)) dut_w1 (
        .clock(clock), .reset(rst_n[0]), .d_addr(d_addr_v[0]), .d_wdata(d_wdata_v[0]),
        .d_store_type(st_v[0]), .d_valid(d_valid_v[0]), .d_ready(d_ready_v[0]),
        .d_rdata(d_rdata_v[0]), .bus_err(bus_err_v[0]), .timer_irq(timer_irq_v[0]));

    periph_responder #(.BASE(BASE), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset(rst_n[1]), .d_addr(d_addr_v[1]), .d_wdata(d_wdata_v[1]),
        .d_store_type(st_v[1]), .d_valid(d_valid_v[1]), .d_ready(d_ready_v[1]),
        .d_rdata(d_rdata_v[1]), .bus_err(bus_err_v[1]), .timer_irq(timer_irq_v[1]));

    periph_responder #(.BASE(BASE), .WAIT_CYCLES(3)) dut_w3 (
        .clock(clock), .reset(rst_n[2]), .d_addr(d_addr_v[2]), .d_wdata(d_wdata_v[2]),
        .d_store_type(st_v[2]), .d_valid(d_valid_v[2]), .d_ready(d_ready_v[2]),
        .d_rdata(d_rdata_v[2]), .bus_err(bus_err_v[2]), .timer_irq(timer_irq_v[2]));

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int st_bytes(input mem_store_type_t st);
        case (st)
            ST_BYTE:  return 1;
            ST_HALF:  return 2;
            ST_WORD:  return 4;
            ST_DWORD: return 8;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [63:0] regValue(input int i, input int idx);
        if (idx < 8) return m_scr[i][idx];
        if (idx == 8) return m_count[i];
        if (idx == 9) return m_cmp[i];
        return 64'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset(input int i);
        m_valid[i] = 1'b1;
        m_count[i] = '0;
        m_cmp[i]   = '1;
        m_irq[i]   = 1'b0;
        m_pend[i]  = 1'b0;
        m_cyc[i]   = 0;
        for (int r = 0; r < 8; r++) m_scr[i][r] = '0;
    endtask

    // One cycle of the model: predict this cycle's outputs, then advance state.
    task automatic modelStep(input int i);
        logic [63:0] off, e_rdata;
        bit is_resp, is_st, inwin, e_err, e_ready, commit;
        int nb, idx, lane;
        if (!m_valid[i]) begin
            if (!rst_n[i]) modelReset(i);
            return;
        end
        is_resp = m_pend[i] && (m_cyc[i] == m_due[i]);
        off     = m_addr[i] - BASE;
        nb      = st_bytes(m_st[i]);
        is_st   = nb > 0;
        inwin   = off < 64'h50;
        e_err   = !inwin;
        if (is_st && inwin && (off % 64'(nb)) != 64'd0) e_err = 1'b1;
        idx     = inwin ? int'(off / 64'd8) : 0;
        e_ready = rst_n[i] && is_resp;
        e_rdata = (e_ready && !is_st && inwin) ? regValue(i, idx) : 64'd0;
        checkOutput($sformatf("inst%0d cyc%0d ready/err/irq", i, m_cyc[i]),
                    {61'd0, d_ready_v[i], bus_err_v[i], timer_irq_v[i]},
                    {61'd0, e_ready, e_ready && e_err, m_irq[i]});
        checkOutput($sformatf("inst%0d cyc%0d rdata", i, m_cyc[i]), d_rdata_v[i], e_rdata);

        if (!rst_n[i]) begin
            modelReset(i);
            return;
        end
        commit = is_resp && is_st && !e_err;
        if (commit && idx == 9) m_irq[i] = 1'b0;
        else if (m_count[i] == m_cmp[i]) m_irq[i] = 1'b1;
        if (commit) begin
            for (int b = 0; b < nb; b++) begin
                lane = int'(off % 64'd8) + b;
                if (idx < 8) m_scr[i][idx][8*lane +: 8] = m_wdata[i][8*b +: 8];
                else if (idx == 9) m_cmp[i][8*lane +: 8] = m_wdata[i][8*b +: 8];
            end
        end
        m_count[i] = m_count[i] + 64'd1;
        if (is_resp) begin
            m_pend[i] = 1'b0;
        end else if (!m_pend[i] && d_valid_v[i]) begin
            m_pend[i]  = 1'b1;
            m_due[i]   = m_cyc[i] + longint'(wait_of(i)) + 1;
            m_addr[i]  = d_addr_v[i];
            m_wdata[i] = d_wdata_v[i];
            m_st[i]    = st_v[i];
        end
        m_cyc[i]++;
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) modelStep(i);
    end

    // Issues one request, waits a bounded time for d_ready, and returns in the next idle cycle.
    task automatic applyStimulus(input int i, input mem_store_type_t st, input logic [63:0] addr,
                                 input logic [63:0] wdata, output int latency,
                                 output logic [63:0] rdata, output logic berr);
        d_valid_v[i] = 1'b1;
        d_addr_v[i]  = addr;
        d_wdata_v[i] = wdata;
        st_v[i]      = st;
        latency = 0;
        while (latency < 40) begin
            @(posedge clock); #1;
            latency++;
            if (d_ready_v[i]) break;
        end
        checkOutput($sformatf("inst%0d ready within bound", i), {63'd0, d_ready_v[i]}, 64'd1);
        rdata = d_rdata_v[i];
        berr  = bus_err_v[i];
        d_valid_v[i] = 1'b0;
        st_v[i]      = ST_NONE;
        @(posedge clock); #1;
    endtask

    task automatic resetInst(input int i);
        rst_n[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_n[i] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = '0;
        d_valid_v = '0;
        d_addr_v  = '0;
        d_wdata_v = '0;
        for (int i = 0; i < NI; i++) st_v[i] = ST_NONE;
        b2b_addr[0] = BASE;
        b2b_addr[1] = BASE + 64'h08;
        b2b_addr[2] = BASE + 64'h40;
        b2b_addr[3] = BASE + 64'h100;
        repeat (3) @(posedge clock);
        #1;
        rst_n = '1;

        checkOutput("reset d_ready", {61'd0, d_ready_v}, 64'd0);
        checkOutput("reset bus_err", {61'd0, bus_err_v}, 64'd0);
        checkOutput("reset timer_irq", {61'd0, timer_irq_v}, 64'd0);
        checkOutput("reset d_rdata", d_rdata_v[0] | d_rdata_v[1] | d_rdata_v[2], 64'd0);

        // WAIT_CYCLES=1: DWORD round trip
        applyStimulus(0, ST_DWORD, BASE + 64'h08, 64'h1122334455667788, lat, rd, err);
        checkOutput("dword store latency", 64'(lat), 64'd2);
        checkOutput("dword store bus_err", {63'd0, err}, 64'd0);
        applyStimulus(0, ST_NONE, BASE + 64'h08, 64'd0, lat, rd, err);
        checkOutput("dword load latency", 64'(lat), 64'd2);
        checkOutput("dword load data", rd, 64'h1122334455667788);
        checkOutput("dword load bus_err", {63'd0, err}, 64'd0);

        applyStimulus(0, ST_BYTE, BASE + 64'h13, 64'hAB, lat, rd, err);
        applyStimulus(0, ST_NONE, BASE + 64'h10, 64'd0, lat, rd, err);
        checkOutput("byte lane 3 data", rd, 64'h00000000AB000000);

        applyStimulus(0, ST_HALF, BASE + 64'h0E, 64'hBEEF, lat, rd, err);
        checkOutput("half store bus_err", {63'd0, err}, 64'd0);
        applyStimulus(0, ST_NONE, BASE + 64'h0B, 64'd0, lat, rd, err);
        checkOutput("half merge via unaligned load", rd, 64'hBEEF334455667788);

        applyStimulus(0, ST_DWORD, BASE + 64'h20, 64'hCAFEF00D12345678, lat, rd, err);
        applyStimulus(0, ST_WORD, BASE + 64'h22, 64'hFFFFFFFF, lat, rd, err);
        checkOutput("misaligned word bus_err", {63'd0, err}, 64'd1);
        checkOutput("misaligned word latency", 64'(lat), 64'd2);
        applyStimulus(0, ST_NONE, BASE + 64'h20, 64'd0, lat, rd, err);
        checkOutput("misaligned word dropped", rd, 64'hCAFEF00D12345678);

        applyStimulus(0, ST_NONE, BASE + 64'h100, 64'd0, lat, rd, err);
        checkOutput("out of window rdata", rd, 64'd0);
        checkOutput("out of window bus_err", {63'd0, err}, 64'd1);
        applyStimulus(0, ST_NONE, BASE - 64'h08, 64'd0, lat, rd, err);
        checkOutput("below base bus_err", {63'd0, err}, 64'd1);
        applyStimulus(0, ST_DWORD, BASE + 64'h40, 64'h1234, lat, rd, err);
        checkOutput("count store no error", {63'd0, err}, 64'd0);

        // Timer: COUNT read at RESP, then COMPARE=50 committed at count 10
        resetInst(0);
        repeat (3) @(posedge clock);
        #1;
        d_valid_v[0] = 1'b1;
        d_addr_v[0]  = BASE + 64'h40;
        st_v[0]      = ST_NONE;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("count load ready", {63'd0, d_ready_v[0]}, 64'd1);
        checkOutput("count load value", d_rdata_v[0], 64'd5);
        d_valid_v[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        d_valid_v[0] = 1'b1;
        d_addr_v[0]  = BASE + 64'h48;
        d_wdata_v[0] = 64'd50;
        st_v[0]      = ST_DWORD;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("compare store ready", {63'd0, d_ready_v[0]}, 64'd1);
        d_valid_v[0] = 1'b0;
        st_v[0]      = ST_NONE;
        repeat (40) @(posedge clock);
        #1;
        checkOutput("irq low at count 50", {63'd0, timer_irq_v[0]}, 64'd0);
        @(posedge clock); #1;
        checkOutput("irq high at count 51", {63'd0, timer_irq_v[0]}, 64'd1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("irq held", {63'd0, timer_irq_v[0]}, 64'd1);
        applyStimulus(0, ST_DWORD, BASE + 64'h48, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, err);
        checkOutput("irq cleared by compare store", {63'd0, timer_irq_v[0]}, 64'd0);

        // WAIT_CYCLES=0: valid held across four loads
        applyStimulus(1, ST_DWORD, BASE, 64'h0123456789ABCDEF, lat, rd, err);
        checkOutput("w0 store latency", 64'(lat), 64'd1);
        applyStimulus(1, ST_DWORD, BASE + 64'h08, 64'h0F0E0D0C0B0A0908, lat, rd, err);
        d_valid_v[1] = 1'b1;
        st_v[1]      = ST_NONE;
        for (int k = 0; k < 4; k++) begin
            d_addr_v[1] = b2b_addr[k];
            checkOutput($sformatf("b2b %0d idle ready", k), {63'd0, d_ready_v[1]}, 64'd0);
            @(posedge clock); #1;
            checkOutput($sformatf("b2b %0d resp ready", k), {63'd0, d_ready_v[1]}, 64'd1);
            if (k == 0) checkOutput("b2b 0 data", d_rdata_v[1], 64'h0123456789ABCDEF);
            if (k == 1) checkOutput("b2b 1 data", d_rdata_v[1], 64'h0F0E0D0C0B0A0908);
            if (k == 3) checkOutput("b2b 3 bus_err", {63'd0, bus_err_v[1]}, 64'd1);
            @(posedge clock); #1;
        end
        d_valid_v[1] = 1'b0;

        // WAIT_CYCLES=3: reset in the second wait cycle discards the store
        d_valid_v[2] = 1'b1;
        d_addr_v[2]  = BASE;
        d_wdata_v[2] = 64'h5555AAAA5555AAAA;
        st_v[2]      = ST_DWORD;
        repeat (2) @(posedge clock);
        #1;
        rst_n[2]     = 1'b0;
        d_valid_v[2] = 1'b0;
        st_v[2]      = ST_NONE;
        @(posedge clock); #1;
        rst_n[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("aborted store ready %0d", k), {63'd0, d_ready_v[2]}, 64'd0);
            @(posedge clock); #1;
        end
        applyStimulus(2, ST_NONE, BASE, 64'd0, lat, rd, err);
        checkOutput("w3 load latency", 64'(lat), 64'd4);
        checkOutput("aborted store not written", rd, 64'd0);
        applyStimulus(2, ST_DWORD, BASE, 64'h5555AAAA5555AAAA, lat, rd, err);
        applyStimulus(2, ST_NONE, BASE, 64'd0, lat, rd, err);
        checkOutput("w3 store after reset", rd, 64'h5555AAAA5555AAAA);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/periph_responder.md
PERIPH_RESPONDER -- requirements
Module: periph_responder

Interface
REQ-001 SHALL have parameter BASE, default 64'h2000_0000, byte address of the responder window.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, number of idle cycles inserted before each response (legal range 0..15).
REQ-003 SHALL have the port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset, input, 1, a synchronous, active-low reset.
REQ-005 SHALL have the port d_addr, input, 64, the request byte address.
REQ-006 SHALL have the port d_wdata, input, 64, the unshifted store data; the store occupies its low bytes.
REQ-007 SHALL have the port d_store_type, input, mem_store_type_t, the store width (NONE means load).
REQ-008 SHALL have the port d_valid, input, 1, the request; held high by the initiator until d_ready.
REQ-009 SHALL have the port d_ready, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have the port d_rdata, output, 64, the aligned doubleword read data; valid only while d_ready is high, else 0.
REQ-011 SHALL have the port bus_err, output, 1, a one-cycle pulse coincident with d_ready for an out-of-window or misaligned access.
REQ-012 SHALL have the port timer_irq, output, 1, a level interrupt intended for one interrupt_sources bit.

Function
REQ-013 SHALL decode offset = d_addr - BASE as follows:
- 0x00-0x38: eight 64-bit scratch registers, read/write.
- 0x40: COUNT, read-only; writes ignored without error.
- 0x48: COMPARE, read/write.
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP with these transitions:
- IDLE to WAIT when d_valid is high and WAIT_CYCLES > 0.
- IDLE to RESP when d_valid is high and WAIT_CYCLES == 0.
- WAIT to RESP after WAIT_CYCLES cycles.
- RESP to IDLE unconditionally.
REQ-015 SHALL latch d_addr, d_wdata and d_store_type on IDLE exit, and ignore input changes until the return to IDLE.
REQ-016 SHALL assert d_ready exactly WAIT_CYCLES+1 cycles after the first IDLE cycle that samples d_valid high; minimum latency is 1.
REQ-017 SHALL treat d_valid high in the cycle after RESP as a new request; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-018 SHALL complete an accepted request even if d_valid drops during WAIT.
REQ-019 SHALL commit stores in the RESP cycle, writing byte lanes starting at offset[2:0]:
- BYTE: 1 lane.
- HALF: 2 lanes, requires offset[0]==0.
- WORD: 4 lanes, requires offset[1:0]==0.
- DWORD: 8 lanes, requires offset[2:0]==0.
REQ-020 SHALL drop a misaligned store (no lanes written), complete it normally and pulse bus_err.
REQ-021 SHALL handle out-of-window addresses (including d_addr < BASE) by responding with d_rdata=0, writing nothing and pulsing bus_err; the initiator is never left waiting.
REQ-022 SHALL return the full aligned doubleword for loads; byte and halfword extraction is the initiator's job.
REQ-023 SHALL increment COUNT every cycle and wrap from 2^64-1 to 0; a load returns the COUNT value at the RESP cycle.
REQ-024 SHALL set timer_irq on the cycle after COUNT == COMPARE and hold it until any store to offset 0x48.
REQ-025 SHALL let a COMPARE store coincident with a match win: timer_irq stays 0, and the new COMPARE value is used from the next cycle.

Reset
REQ-026 SHALL, while reset==0 at a clock edge:
- Force the FSM to IDLE.
- Drive d_ready, bus_err, timer_irq and d_rdata to 0.
- Set scratch registers and COUNT to 0, and COMPARE to all-ones.
REQ-027 SHALL discard an in-flight request on reset assertion in WAIT or RESP, with no store committed if reset coincides with RESP.

Structure
REQ-028 SHALL take mem_store_type_t from the shared structures package, and SHALL place the offset constants and the FSM state enum there.
REQ-029 SHALL place COUNT, COMPARE and timer_irq in the sub-module periph_timer, with its store-enable and data driven by the responder decode.

Verification
REQ-030 SHALL cover a WAIT_CYCLES=1 DWORD store: 0x1122334455667788 to BASE+0x08, then a load of BASE+0x08 -> d_ready 2 cycles after each request, read returns 0x1122334455667788, bus_err=0.
REQ-031 SHALL cover a BYTE store: 0xAB to BASE+0x13 over a zeroed register -> load of BASE+0x10 returns 0x00000000AB000000.
REQ-032 SHALL cover misaligned and out-of-window accesses: WORD store to BASE+0x22 -> bus_err pulse, register unchanged; load of BASE+0x100 -> d_rdata=0, bus_err=1.
REQ-033 SHALL cover the timer: COMPARE=50 written at count 10 -> timer_irq rises the cycle after COUNT==50; a COMPARE store clears it.
REQ-034 SHALL cover reset during WAIT: with WAIT_CYCLES=3, a store to BASE+0x00 with reset low in the 2nd WAIT cycle -> no d_ready, register stays 0, next request served normally.
REQ-035 SHALL cover WAIT_CYCLES=0 back-to-back: d_valid held high across 4 loads -> d_ready high every other cycle.
